// File: rtl/layer6_pixel_buffer_pkg.sv
// layer6_buf_pkg: shared state type, size defaults and the
// (row, col) -> (bank, word) mapping for the layer-6 pixel buffer.
package layer6_buf_pkg;

   localparam int IN_WIDTH_DEF = 16;
   localparam int DATA_W_DEF   = 128;
   localparam int ADDR_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_DONE  = 2'd1,
      ST_SERVE = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0]  bank;
      logic [15:0] word;
   } bank_loc_t;

   // Row/column parity picks the bank, so every 2x2 window spans all four.
   function automatic bank_loc_t bank_map(
      input logic [15:0] row,
      input logic [15:0] col,
      input int          half
   );
      bank_loc_t loc;
      loc.bank = {row[0], col[0]};
      loc.word = 16'(32'(row >> 1) * half + 32'(col >> 1));
      return loc;
   endfunction

endpackage

// File: rtl/layer6_pixel_buffer_if.sv
// layer6_pixel_buffer_if: layer-5 write port plus the pooling-block
// read port of the layer-6 pixel buffer.
interface layer6_pixel_buffer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_row;
   logic [ADDR_W-1:0] wr_col;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              pixel_store_done;
   logic              wr_overflow;

   logic              read_pixel_signal;
   logic [ADDR_W-1:0] read_row_addr;
   logic [ADDR_W-1:0] read_col_addr;
   logic              layer6_calculation_done;

   logic [DATA_W-1:0] input_data_even_even;
   logic [DATA_W-1:0] input_data_even_odd;
   logic [DATA_W-1:0] input_data_odd_even;
   logic [DATA_W-1:0] input_data_odd_odd;

   modport master (
      output wr_en, wr_row, wr_col, wr_data,
      output read_pixel_signal, read_row_addr, read_col_addr,
      output layer6_calculation_done,
      input  wr_ready, pixel_store_done, wr_overflow,
      input  input_data_even_even, input_data_even_odd,
      input  input_data_odd_even, input_data_odd_odd
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data,
      input  read_pixel_signal, read_row_addr, read_col_addr,
      input  layer6_calculation_done,
      output wr_ready, pixel_store_done, wr_overflow,
      output input_data_even_even, input_data_even_odd,
      output input_data_odd_even, input_data_odd_odd
   );

endinterface

// File: rtl/layer6_pixel_buffer_bank.sv
// pixel_bank: one-write, one-read register array with a registered,
// zeroable read port. Contents are deliberately left unreset.
module pixel_bank #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 128,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   input  logic              i_rzero,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Same-edge write/read returns the pre-write word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/layer6_pixel_buffer.sv
// layer6_pixel_buffer: four-bank feature-map store feeding the
// layer-6 2x2 max-pool; one full window per read strobe.
module layer6_pixel_buffer
   import layer6_buf_pkg::*;
#(
   parameter int IN_WIDTH = IN_WIDTH_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input logic                 clk,
   input logic                 rst,
   layer6_pixel_buffer_if.slave bus
);

   localparam int HALF  = IN_WIDTH / 2;
   localparam int DEPTH = HALF * HALF;
   localparam int TOTAL = IN_WIDTH * IN_WIDTH;
   localparam int AW    = $clog2(DEPTH);

   state_e            r_state;
   state_e            w_next;
   logic [15:0]       r_cnt;
   logic              r_ovf;

   logic              w_ready;
   logic              w_done;
   logic              w_in_range;
   logic              w_acc;
   logic              w_last;
   logic              w_release;
   bank_loc_t         w_wloc;
   logic [AW-1:0]     w_wword;
   logic              w_rd_ok;
   logic [AW-1:0]     w_raddr;
   logic [DATA_W-1:0] w_rdata [4];

   assign w_in_range = (bus.wr_row < ADDR_W'(IN_WIDTH))
                    && (bus.wr_col < ADDR_W'(IN_WIDTH));
   assign w_acc      = bus.wr_en && w_ready && w_in_range;
   assign w_last     = w_acc && (r_cnt == 16'(TOTAL - 1));
   assign w_release  = (r_state == ST_SERVE)
                    && bus.layer6_calculation_done;

   assign w_wloc  = bank_map(16'(bus.wr_row), 16'(bus.wr_col), HALF);
   assign w_wword = AW'(w_wloc.word);

   // A pooled (r, c) is the same word index in every bank.
   assign w_rd_ok = (bus.read_row_addr < ADDR_W'(HALF))
                 && (bus.read_col_addr < ADDR_W'(HALF));
   assign w_raddr = w_rd_ok
                  ? AW'(32'(bus.read_row_addr) * HALF
                        + 32'(bus.read_col_addr))
                  : '0;

   for (genvar k = 0; k < 4; k++) begin : g_bank
      pixel_bank #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W),
         .AW     (AW)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_acc && (w_wloc.bank == 2'(k))),
         .i_waddr (w_wword),
         .i_wdata (bus.wr_data),
         .i_re    (bus.read_pixel_signal),
         .i_raddr (w_raddr),
         .i_rzero (!w_rd_ok),
         .o_rdata (w_rdata[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         ST_FILL: begin
            w_ready = 1'b1;
            if (w_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_SERVE;
         end
         ST_SERVE: begin
            if (bus.layer6_calculation_done) begin
               w_next = ST_FILL;
            end
         end
         default: w_next = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_release) begin
         r_cnt <= '0;
      end else if (w_acc) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Any write that cannot be stored is remembered until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (bus.wr_en && (!w_ready || !w_in_range)) begin
         r_ovf <= 1'b1;
      end
   end

   assign bus.wr_ready             = w_ready;
   assign bus.pixel_store_done     = w_done;
   assign bus.wr_overflow          = r_ovf;
   assign bus.input_data_even_even = w_rdata[0];
   assign bus.input_data_even_odd  = w_rdata[1];
   assign bus.input_data_odd_even  = w_rdata[2];
   assign bus.input_data_odd_odd   = w_rdata[3];

endmodule

// File: doc/layer6_pixel_buffer.md
# layer6_pixel_buffer

Four-bank pixel store between the layer-5 convolution and the layer-6 2x2 max-pooling stage. It accepts one full feature map of 128-bit pixels from layer 5, addressed by row and column. It then pulses `pixel_store_done` and serves pooling-window reads: each read returns the four pixels of one 2x2 window in parallel. It is the responder for the pooling block's `read_pixel_signal` / `read_row_addr` / `read_col_addr` interface.

## Interface
- `IN_WIDTH`, 16: input feature-map height and width, in pixels; must be even.
- `DATA_W`, 128: pixel width (8 channels x 16 bit).
- `ADDR_W`, 16: address port width (`WORDLENGTH`).
---
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  layer-5 `save_enable`; write strobe.
- `wr_row`  in  ADDR_W  input-map row.
- `wr_col`  in  ADDR_W  input-map column.
- `wr_data`  in  DATA_W  pixel to store.
- `wr_ready`  out  1  high while the block accepts writes.
- `pixel_store_done`  out  1  one-cycle pulse: the map is complete.
- `read_pixel_signal`  in  1  read strobe from the pooling block.
- `read_row_addr`  in  ADDR_W  pooled row r, 0..IN_WIDTH/2-1.
- `read_col_addr`  in  ADDR_W  pooled column c, 0..IN_WIDTH/2-1.
- `layer6_calculation_done`  in  1  pooling finished; releases the buffer.
- `input_data_even_even`  out  DATA_W  pixel (2r, 2c).
- `input_data_even_odd`  out  DATA_W  pixel (2r, 2c+1).
- `input_data_odd_even`  out  DATA_W  pixel (2r+1, 2c).
- `input_data_odd_odd`  out  DATA_W  pixel (2r+1, 2c+1).
- `wr_overflow`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- **Storage.** Four banks are selected by {`wr_row[0]`, `wr_col[0]`}. Each bank holds (IN_WIDTH/2)^2 words, indexed by `(wr_row>>1)*(IN_WIDTH/2) + (wr_col>>1)`. Bank contents are not reset.
- **FSM states.** FILL, DONE, SERVE. Reset state is FILL.
- **FILL.**
  - `wr_ready`=1.
  - A write is accepted when `wr_en`=1, `wr_row` < IN_WIDTH and `wr_col` < IN_WIDTH. Each accepted write increments a 16-bit write counter.
  - Out-of-range writes are dropped, are not counted, and set `wr_overflow`.
  - Repeated writes to the same location overwrite the data and still count.
  - When an accepted write brings the count to IN_WIDTH^2, go to DONE on the next edge.
- **DONE.**
  - Lasts one cycle with `pixel_store_done`=1 and `wr_ready`=0.
  - Then go to SERVE unconditionally.
- **SERVE.**
  - `wr_ready`=0. Any `wr_en` is ignored and sets `wr_overflow`.
  - Reads are served (see Timing).
  - `layer6_calculation_done`=1 moves the FSM to FILL on the next edge and clears the write counter.
- **Read addressing.**
  - Reads are served in every state. Data read outside SERVE is whatever the banks currently hold.
  - A read with `read_row_addr` or `read_col_addr` ≥ IN_WIDTH/2 returns all zeros.
- **Release in FILL/DONE.** `layer6_calculation_done` asserted in FILL or DONE is ignored.

## Timing
- **Reset values.** `wr_ready`=1, `pixel_store_done`=0, `wr_overflow`=0, all four data outputs 0, write counter 0.
- **Write.** Data is sampled at the edge where `wr_en`=1 and `wr_ready`=1. It is readable from the next cycle.
- **Read latency: 1 cycle.** Address and strobe are sampled at edge N. The four outputs are registered and valid after edge N.
  - Outputs hold their value while `read_pixel_signal`=0.
  - Back-to-back reads give one window per cycle.
- **Done pulse.** The last accepted write is at edge N. `pixel_store_done` is high during cycle N+1 only.
- **Write vs. read, same address, same edge.** The read returns the old data.
- **Reset mid-fill or mid-serve.** Return to FILL with the counter at 0. The caller must rewrite the full map.

## Structure
- **Package `layer6_buf_pkg`:**
  - FSM state enum;
  - `IN_WIDTH` / `DATA_W` defaults;
  - a bank-index function mapping (row, col) to (bank, word).
- **Sub-module `pixel_bank`:** single-port-write, single-read register array with a registered read, of depth (IN_WIDTH/2)^2 and width DATA_W. It is instantiated four times.
- **Top level:** FSM, write counter, address decode, out-of-range zeroing.

## Test plan
- **Fill and read.** Write all 256 pixels with data = {8{row*16+col}}, then read (r=3, c=5). Expect `pixel_store_done` exactly once, 1 cycle after the last write. Expect outputs 0x..0x6A, 0x..0x6B, 0x..0x7A, 0x..0x7B, replicated in all 8 lanes, 1 cycle after the read.
- **Streaming reads.** Issue 64 back-to-back reads (0,0)..(7,7). Expect one correct window per cycle and no bubbles.
- **Write in SERVE.** Assert `wr_en` during SERVE. Expect `wr_ready`=0, data unchanged and `wr_overflow`=1. Expect no second `pixel_store_done`.
- **Out-of-range.** Write at row 16, and read at (8,0). Expect the write dropped with `wr_overflow`=1, and zero read data.
- **Release and refill.** Pulse `layer6_calculation_done`, then write a new map. Expect FILL, `wr_ready`=1, and the new data returned on reads.
- **Reset mid-fill.** Assert `rst` after 100 writes. Expect all outputs to return to their reset values. Expect 256 further writes to be needed before `pixel_store_done`.
